// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, tag-word layout and FSM state type for the
// data-cache controller. Geometry is fixed: 16 sets, 2 ways, 256-bit lines.
package dcache_pkg;

    localparam int TAG_W      = 23;
    localparam int IDX_W      = 4;
    localparam int LINE_W     = 256;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 5;
    localparam int TAGWORD_W  = 25;
    localparam int VALID_BIT  = 24;
    localparam int DIRTY_BIT  = 23;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MISS      = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_UPDATE    = 3'd4
    } state_t;

    // Build an SRAM tag word: valid is always set when the controller writes.
    function automatic logic [TAGWORD_W-1:0] make_tag_word(input logic dirty,
                                                           input logic [TAG_W-1:0] tag);
        logic [TAGWORD_W-1:0] w;
        w             = '0;
        w[VALID_BIT]  = 1'b1;
        w[DIRTY_BIT]  = dirty;
        w[TAG_W-1:0]  = tag;
        return w;
    endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// dcache_word_merge: selects one 32-bit word out of a 256-bit line and, in
// parallel, produces the same line with that word replaced. The read-hit
// path uses o_word, the write-hit path uses o_line.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]     i_line,
    input  logic [WORD_SEL_W-1:0] i_sel,
    input  logic [WORD_W-1:0]     i_word,
    output logic [WORD_W-1:0]     o_word,
    output logic [LINE_W-1:0]     o_line
);

    logic [7:0] w_bit_base;

    assign w_bit_base = {i_sel, 5'b00000};

    // Word extract and word insert share the same bit offset.
    always_comb begin
        o_word = i_line[w_bit_base +: WORD_W];
        o_line = i_line;
        o_line[w_bit_base +: WORD_W] = i_word;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: controller for the 2-way set-associative data-cache SRAM.
// Hits are served combinationally from the SRAM; misses write back a dirty
// victim, refill the line from memory and rewrite the SRAM, then re-check.
// Optional build macro DCACHE_PERF_CNT_EN adds saturating hit/miss counters.
//
// state        | meaning
// ------------ | ---------------------------------------------------------
// ST_IDLE      | serve hits; on a miss capture the LRU victim
// ST_MISS      | choose write-back (valid+dirty victim) or straight refill
// ST_WRITEBACK | victim line written to memory, wait for mem_ack_i
// ST_REFILL    | requested line read from memory, wait for mem_ack_i
// ST_UPDATE    | refilled line written into the SRAM's LRU way
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 sram_enable_o,
    output logic                 sram_write_o,
    output logic [3:0]           sram_addr_o,
    output logic [24:0]          sram_tag_o,
    output logic [255:0]         sram_data_o,
    input  logic [24:0]          sram_tag_i,
    input  logic [255:0]         sram_data_i,
    input  logic                 sram_hit_i,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [255:0]         mem_data_o,
    input  logic [255:0]         mem_data_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    state_t                  r_state;
    logic [TAGWORD_W-1:0]    r_victim_tag;
    logic [LINE_W-1:0]       r_victim_line;
    logic [LINE_W-1:0]       r_refill_line;
    logic                    r_mem_enable;
    logic                    r_mem_write;
    logic [31:0]             r_mem_addr;
    logic [LINE_W-1:0]       r_mem_data;

    logic [TAG_W-1:0]        w_cpu_tag;
    logic [IDX_W-1:0]        w_idx;
    logic [WORD_SEL_W-1:0]   w_word_sel;
    logic [1:0]              w_unused_byte_off;
    logic [WORD_W-1:0]       w_hit_word;
    logic [LINE_W-1:0]       w_merged_line;
    logic                    w_victim_dirty;

    assign w_cpu_tag         = cpu_addr_i[31:9];
    assign w_idx             = cpu_addr_i[8:5];
    assign w_word_sel        = cpu_addr_i[4:2];
    assign w_unused_byte_off = cpu_addr_i[1:0];
    assign w_victim_dirty    = r_victim_tag[VALID_BIT] & r_victim_tag[DIRTY_BIT];

    dcache_word_merge u_word_merge (
        .i_line (sram_data_i),
        .i_sel  (w_word_sel),
        .i_word (cpu_data_i),
        .o_word (w_hit_word),
        .o_line (w_merged_line)
    );

    // Miss-handling FSM; memory-side outputs are registered so they are
    // stable from the first cycle of WRITEBACK/REFILL through the ack.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= ST_IDLE;
            r_victim_tag  <= '0;
            r_victim_line <= '0;
            r_refill_line <= '0;
            r_mem_enable  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req_i && !sram_hit_i) begin
                        r_victim_tag  <= sram_tag_i;
                        r_victim_line <= sram_data_i;
                        r_state       <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    r_mem_enable <= 1'b1;
                    if (w_victim_dirty) begin
                        r_mem_write <= 1'b1;
                        r_mem_addr  <= {r_victim_tag[TAG_W-1:0], w_idx, {OFFSET_W{1'b0}}};
                        r_mem_data  <= r_victim_line;
                        r_state     <= ST_WRITEBACK;
                    end else begin
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_cpu_tag, w_idx, {OFFSET_W{1'b0}}};
                        r_state     <= ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        // Refill request follows immediately; enable stays high.
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= {w_cpu_tag, w_idx, {OFFSET_W{1'b0}}};
                        r_state     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        r_refill_line <= mem_data_i;
                        r_mem_enable  <= 1'b0;
                        r_state       <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_mem_enable <= 1'b0;
                    r_mem_write  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign cpu_data_o   = w_hit_word;

    // SRAM and CPU handshake; hits complete in the same cycle. In IDLE the
    // dirty bit of the compare tag follows cpu_write_i: the SRAM only stores
    // it on a write hit, and keeping it independent of sram_hit_i avoids a
    // combinational loop through the SRAM's tag compare.
    always_comb begin
        cpu_stall_o   = 1'b1;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_addr_o   = w_idx;
        sram_tag_o    = make_tag_word(1'b0, w_cpu_tag);
        sram_data_o   = w_merged_line;
        case (r_state)
            ST_IDLE: begin
                cpu_stall_o   = cpu_req_i & ~sram_hit_i;
                sram_enable_o = cpu_req_i;
                sram_tag_o    = make_tag_word(cpu_write_i, w_cpu_tag);
                sram_write_o  = cpu_req_i & cpu_write_i & sram_hit_i;
            end
            ST_UPDATE: begin
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_tag_o    = make_tag_word(1'b0, w_cpu_tag);
                sram_data_o   = r_refill_line;
            end
            default: begin
                cpu_stall_o = 1'b1;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_after_miss;

    // Saturating counters; the post-refill re-check hit is not a new hit.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            r_after_miss <= 1'b0;
        end else begin
            if (r_state == ST_UPDATE) begin
                r_after_miss <= 1'b1;
            end else if (r_state == ST_IDLE && cpu_req_i && sram_hit_i) begin
                if (r_after_miss) begin
                    r_after_miss <= 1'b0;
                end else if (r_hit_cnt != 32'hFFFF_FFFF) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end
            if (r_state == ST_IDLE && cpu_req_i && !sram_hit_i &&
                r_miss_cnt != 32'hFFFF_FFFF) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: bench for dcache_ctrl with a 2-way LRU SRAM model, a
// latency-programmable memory responder and a flat-memory reference model.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic         sram_enable_o, sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_hit_i;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
        .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: flat word-addressed memory ----------
    logic [31:0]  ref_w [int];
    logic [255:0] mem   [int];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F96;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & ~32'h3;
        if (ref_w.exists(int'(wa))) return ref_w[int'(wa)];
        return init_word(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_read(la + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [255:0] init_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [255:0] mem_read(input logic [31:0] la);
        if (mem.exists(int'(la))) return mem[int'(la)];
        return init_line(la);
    endfunction

    // ---------------- 2-way LRU SRAM model --------------------------------
    logic [24:0]  tag_mem [16][2] = '{default: '0};
    logic [255:0] dat_mem [16][2] = '{default: '0};
    logic         lru     [16]    = '{default: 1'b0};
    int           sram_wr_cnt = 0;
    logic         hit_way;
    logic         w_way;

    always_comb begin
        sram_hit_i  = 1'b0;
        hit_way     = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (tag_mem[sram_addr_o][w][24] &&
                tag_mem[sram_addr_o][w][22:0] == sram_tag_o[22:0]) begin
                sram_hit_i = 1'b1;
                hit_way    = 1'(w);
            end
        end
        if (sram_hit_i) begin
            sram_tag_i  = tag_mem[sram_addr_o][hit_way];
            sram_data_i = dat_mem[sram_addr_o][hit_way];
        end else begin
            sram_tag_i  = tag_mem[sram_addr_o][lru[sram_addr_o]];
            sram_data_i = dat_mem[sram_addr_o][lru[sram_addr_o]];
        end
    end

    assign w_way = sram_hit_i ? hit_way : lru[sram_addr_o];

    always @(posedge clk_i) begin
        if (sram_enable_o) begin
            if (sram_write_o) begin
                tag_mem[sram_addr_o][w_way] <= sram_tag_o;
                dat_mem[sram_addr_o][w_way] <= sram_data_o;
                lru[sram_addr_o]            <= ~w_way;
                sram_wr_cnt                 <= sram_wr_cnt + 1;
            end else if (sram_hit_i) begin
                lru[sram_addr_o] <= ~hit_way;
            end
        end
    end

    // ---------------- memory responder -------------------------------------
    int           ack_delay = 0;
    bit           force_ack = 0;
    int           last_en = 0;
    logic         txn_wr_q[$];
    logic [31:0]  txn_addr_q[$];

    initial begin
        bit           busy, drop_chk;
        int           wait_left, en_cnt;
        logic         cur_wr;
        logic [31:0]  cur_addr;
        logic [255:0] cur_data;
        busy = 0; drop_chk = 0; wait_left = 0; en_cnt = 0;
        cur_wr = 0; cur_addr = 0; cur_data = 0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (force_ack) begin
                mem_ack_i = 1'b1;
                force_ack = 0;
                busy = 0;
                drop_chk = 0;
            end else if (!rst_n_i) begin
                busy = 0;
                drop_chk = 0;
            end else begin
                if (drop_chk) begin
                    chk("mem_drop_after_ack", mem_enable_o, 0);
                    drop_chk = 0;
                end
                if (!busy && mem_enable_o) begin
                    busy = 1; wait_left = ack_delay; en_cnt = 0;
                    cur_wr = mem_write_o; cur_addr = mem_addr_o; cur_data = mem_data_o;
                    chk("mem_addr_align", mem_addr_o[4:0], 0);
                    txn_wr_q.push_back(cur_wr);
                    txn_addr_q.push_back(cur_addr);
                    if (cur_wr) chk("wb_data", mem_data_o, ref_line(mem_addr_o));
                end
                if (busy) begin
                    chk("mem_stable", (mem_enable_o && mem_write_o == cur_wr &&
                        mem_addr_o == cur_addr && (!cur_wr || mem_data_o == cur_data)), 1);
                    en_cnt++;
                    if (wait_left == 0) begin
                        mem_ack_i = 1'b1;
                        last_en = en_cnt;
                        busy = 0;
                        if (cur_wr) mem[int'(cur_addr)] = cur_data;
                        else begin
                            mem_data_i = mem_read(cur_addr);
                            drop_chk = 1;
                        end
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------------------------
    logic [31:0] exp_q[$];

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n_i && cpu_req_i && !cpu_stall_o && !cpu_write_i) begin
                chk("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("load_data", cpu_data_o, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = data;
        if (wr) ref_w[int'(addr & ~32'h3)] = data;
        else    exp_q.push_back(ref_read(addr));
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1;
            else stalls++;
        end
        chk("req_done", done, 1);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0;
    endtask

    task automatic clear_txn();
        txn_wr_q.delete();
        txn_addr_q.delete();
    endtask

    initial begin
        int           st, wcnt;
        logic [255:0] l;
        bit           found;
        logic         dbit;
        rst_n_i = 1'b0; cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
        repeat (3) @(posedge clk_i); #1;
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_mem_wr", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_sram_en", sram_enable_o, 0);
`ifdef DCACHE_PERF_CNT_EN
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
`endif
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Cold read: clean miss, single refill at 0x40.
        l = init_line(32'h40); l[31:0] = 32'hDEAD_BEEF;
        mem[32'h40] = l; ref_w[32'h40] = 32'hDEAD_BEEF;
        clear_txn();
        do_req(0, 32'h40, 0, st);
        chk("cold_stall_cycles", st, 4);
        chk("cold_txn_cnt", txn_wr_q.size(), 1);
        if (txn_wr_q.size() == 1) begin
            chk("cold_txn_is_read", txn_wr_q[0], 0);
            chk("cold_txn_addr", txn_addr_q[0], 32'h40);
        end
`ifdef DCACHE_PERF_CNT_EN
        chk("cold_miss_cnt", miss_cnt_o, 1);
        chk("cold_hit_cnt", hit_cnt_o, 0);
`endif

        // Store hit, then load back; line must be marked dirty.
        clear_txn();
        do_req(1, 32'h44, 32'h1234_5678, st);
        chk("store_hit_stall", st, 0);
        do_req(0, 32'h44, 0, st);
        chk("load_hit_stall", st, 0);
        chk("hit_no_txn", txn_wr_q.size(), 0);
        found = 0; dbit = 0;
        for (int w = 0; w < 2; w++) begin
            if (tag_mem[2][w][24] && tag_mem[2][w][22:0] == 23'd0) begin
                found = 1; dbit = tag_mem[2][w][23];
            end
        end
        chk("line_present", found, 1);
        chk("dirty_bit", dbit, 1);
`ifdef DCACHE_PERF_CNT_EN
        chk("hit_cnt_after_hits", hit_cnt_o, 2);
`endif

        // Fill the second way of set 2 with a dirty line, then evict the LRU.
        clear_txn();
        do_req(1, 32'h240, 32'hAAAA_5555, st);
        chk("second_way_txn_cnt", txn_wr_q.size(), 1);
        clear_txn();
        do_req(0, 32'h440, 0, st);
        chk("evict_stall_cycles", st, 5);
        chk("evict_txn_cnt", txn_wr_q.size(), 2);
        if (txn_wr_q.size() == 2) begin
            chk("evict_wb_first", txn_wr_q[0], 1);
            chk("evict_wb_addr", txn_addr_q[0], 32'h40);
            chk("evict_refill_second", txn_wr_q[1], 0);
            chk("evict_refill_addr", txn_addr_q[1], 32'h440);
        end
        do_req(0, 32'h440, 0, st);
        chk("evict_then_hit_stall", st, 0);
        do_req(0, 32'h44, 0, st);

        // Slow memory: 10-cycle ack delay.
        ack_delay = 10;
        do_req(0, 32'h1000, 0, st);
        chk("slow_en_cycles", last_en, 11);
        chk("slow_stall_cycles", st, 14);
        ack_delay = 0;

        // Reset in the middle of a refill; late acks must not write the SRAM.
        ack_delay = 20;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h2000;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk_i);
            if (mem_enable_o) found = 1;
        end
        chk("rst_test_refill_started", found, 1);
        repeat (3) @(negedge clk_i);
        #2; rst_n_i = 1'b0; cpu_req_i = 1'b0;
        #1;
        chk("midrst_mem_en", mem_enable_o, 0);
        chk("midrst_stall", cpu_stall_o, 0);
        wcnt = sram_wr_cnt;
        @(posedge clk_i); #1; force_ack = 1;
        @(posedge clk_i); #1; rst_n_i = 1'b1;
        @(posedge clk_i); #1; force_ack = 1;
        repeat (3) @(posedge clk_i); #1;
        chk("late_ack_no_sram_write", sram_wr_cnt, wcnt);
        chk("late_ack_mem_en", mem_enable_o, 0);
        chk("late_ack_stall", cpu_stall_o, 0);
        ack_delay = 0;

        // Randomized traffic over 4 tags x 4 sets to force evictions.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic        wr;
            ack_delay = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            do_req(wr, a, $urandom, st);
        end

        repeat (4) @(posedge clk_i);
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
